// File: rtl/reg_bank_exec.sv
// reg_bank_exec: register bank plus a single-op execute stage driven by the
// idle -> read_data -> store_result control unit.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   read_en           capture regs[src_a_addr], regs[src_b_addr] and op
//   write_en          write ALU result of the captured operands to regs[wr_addr]
//   wr_addr           destination register index
//   src_a_addr        operand A index (sampled with read_en)
//   src_b_addr        operand B index (sampled with read_en)
//   op                00 ADD, 01 SUB, 10 AND, 11 XOR (sampled with read_en)
//   ld_en/ld_addr/ld_data  host load port; loses to a same-cycle write-back
//   dbg_addr/dbg_data combinational debug read, 0 when out of range
//   result, flag      last written-back value and its carry/borrow
//   result_valid      one-cycle pulse after a completed write-back
//   ld_drop           one-cycle pulse after a host load was discarded
//   err               one-cycle pulse after write_en without captured operands
module reg_bank_exec #(
    parameter int unsigned reg_depth  = 8,
    parameter int unsigned data_width = 4,
    localparam int unsigned AW = (reg_depth > 1) ? $clog2(reg_depth) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [AW-1:0]         src_a_addr,
    input  logic [AW-1:0]         src_b_addr,
    input  logic [1:0]            op,
    input  logic                  ld_en,
    input  logic [AW-1:0]         ld_addr,
    input  logic [data_width-1:0] ld_data,
    input  logic [AW-1:0]         dbg_addr,
    output logic [data_width-1:0] dbg_data,
    output logic [data_width-1:0] result,
    output logic                  flag,
    output logic                  result_valid,
    output logic                  ld_drop,
    output logic                  err
);

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpXor = 2'b11
    } op_e;

    // State
    logic [data_width-1:0] regs_q [reg_depth];
    logic [data_width-1:0] regs_d [reg_depth];
    logic [data_width-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic                  opv_q, opv_d;
    logic [data_width-1:0] result_q, result_d;
    logic                  flag_q, flag_d;
    logic                  result_valid_q, result_valid_d;
    logic                  ld_drop_q, ld_drop_d;
    logic                  err_q, err_d;

    // Combinational helpers
    logic                  wb_fire;
    logic [data_width-1:0] rd_a, rd_b;
    logic [data_width:0]   sum_w;
    logic [data_width-1:0] alu_r;
    logic                  alu_flag;

    assign wb_fire = write_en & opv_q;

    // Decoded reads: any index not matching a register (out of range) yields 0.
    always_comb begin
        rd_a     = '0;
        rd_b     = '0;
        dbg_data = '0;
        for (int unsigned i = 0; i < reg_depth; i++) begin
            if (src_a_addr == AW'(i)) rd_a = regs_q[i];
            if (src_b_addr == AW'(i)) rd_b = regs_q[i];
            if (dbg_addr == AW'(i))   dbg_data = regs_q[i];
        end
    end

    // ALU works only from the latched operands, never from the live bank.
    always_comb begin
        alu_r    = '0;
        alu_flag = 1'b0;
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        unique case (op_e'(op_q))
            OpAdd: begin
                alu_r    = sum_w[data_width-1:0];
                alu_flag = sum_w[data_width];
            end
            OpSub: begin
                alu_r    = a_q - b_q;
                alu_flag = (a_q < b_q);
            end
            OpAnd: alu_r = a_q & b_q;
            OpXor: alu_r = a_q ^ b_q;
            default: begin
                alu_r    = '0;
                alu_flag = 1'b0;
            end
        endcase
    end

    // Register bank next state: write-back has priority over the host load.
    always_comb begin
        for (int unsigned i = 0; i < reg_depth; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_fire && (wr_addr == AW'(i))) begin
                regs_d[i] = alu_r;
            end else if (ld_en && !wb_fire && (ld_addr == AW'(i))) begin
                regs_d[i] = ld_data;
            end
        end
    end

    // Operand latches and status next state.
    always_comb begin
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        opv_d          = opv_q;
        result_d       = result_q;
        flag_d         = flag_q;
        result_valid_d = wb_fire;
        ld_drop_d      = ld_en & wb_fire;
        err_d          = write_en & ~opv_q;

        if (wb_fire) begin
            result_d = alu_r;
            flag_d   = alu_flag;
            opv_d    = 1'b0;
        end
        // Capture reads pre-write contents and re-arms even on a write-back cycle.
        if (read_en) begin
            a_d   = rd_a;
            b_d   = rd_b;
            op_d  = op;
            opv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < reg_depth; i++) begin
                regs_q[i] <= '0;
            end
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= 2'b00;
            opv_q          <= 1'b0;
            result_q       <= '0;
            flag_q         <= 1'b0;
            result_valid_q <= 1'b0;
            ld_drop_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < reg_depth; i++) begin
                regs_q[i] <= regs_d[i];
            end
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            opv_q          <= opv_d;
            result_q       <= result_d;
            flag_q         <= flag_d;
            result_valid_q <= result_valid_d;
            ld_drop_q      <= ld_drop_d;
            err_q          <= err_d;
        end
    end

    assign result       = result_q;
    assign flag         = flag_q;
    assign result_valid = result_valid_q;
    assign ld_drop      = ld_drop_q;
    assign err          = err_q;

endmodule
